// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - sequences the round-key generator and serves captured round keys
// A key that matches the already-expanded key is accepted without re-running the generator.
module key_sched_ctrl #(
  parameter int KEY_S   = 128,
  parameter int NR      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_S-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             gen_en,
  output logic [KEY_S-1:0] gen_key,
  input  logic [KEY_S-1:0] gen_round_key,
  input  logic             gen_w_e,
  input  logic             gen_done,
  input  logic [3:0]       rd_round,
  output logic [KEY_S-1:0] rd_key,
  output logic             keys_ready,
  output logic             busy,
  output logic             err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    LAST     = 4'(NR);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, COLLECT} state_t;

  state_t           state, state_nxt;
  logic [KEY_S-1:0] store [0:NR];
  logic [KEY_S-1:0] stored_key;
  logic [3:0]       wr_idx;
  logic [TW-1:0]    tmo_cnt;
  logic             hit;
  logic             wr_ok;

  assign hit   = keys_ready && (key_in == stored_key);
  assign wr_ok = (state == COLLECT) && gen_w_e && (wr_idx <= LAST);

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    gen_en    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid && !hit) state_nxt = START;
      end
      START: begin
        gen_en    = 1'b1;
        busy      = 1'b1;
        state_nxt = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (gen_done || (tmo_cnt == TMO_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gen_key    <= '0;
      stored_key <= '0;
      keys_ready <= 1'b0;
      err        <= 1'b0;
      wr_idx     <= '0;
      tmo_cnt    <= '0;
      rd_key     <= '0;
    end else begin
      state  <= state_nxt;
      rd_key <= (keys_ready && rd_round <= LAST) ? store[rd_round] : '0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            err <= 1'b0;
            if (!hit) begin
              stored_key <= key_in;
              gen_key    <= key_in;
              keys_ready <= 1'b0;
            end
          end
        end
        START: begin
          wr_idx  <= '0;
          tmo_cnt <= '0;
        end
        COLLECT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // wr_idx stops at NR+1 so surplus strobes are flagged, never wrapped
          if (gen_w_e) begin
            if (wr_idx <= LAST) wr_idx <= wr_idx + 4'd1;
            else                err    <= 1'b1;
          end
          if (gen_done) begin
            if (gen_w_e && wr_idx == LAST) keys_ready <= 1'b1;
            else                           err        <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) store[wr_idx] <= gen_round_key;
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb/tb_key_sched_ctrl.sv - directed bench for key_sched_ctrl with a table-driven generator model
module tb_key_sched_ctrl;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [127:0] RK_A [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  localparam logic [127:0] RK_B [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         gen_en;
  logic [127:0] gen_key;
  logic [127:0] gen_round_key = '0;
  logic         gen_w_e = 1'b0;
  logic         gen_done = 1'b0;
  logic [3:0]   rd_round = '0;
  logic [127:0] rd_key;
  logic         keys_ready;
  logic         busy;
  logic         err;

  int n_vec = 0;
  int n_err = 0;
  // 0 normal, 1 done after 9 strobes, 2 never done then late strobe, 3 normal with a gap
  int gen_mode = 0;

  key_sched_ctrl #(.KEY_S(128), .NR(10), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .gen_en(gen_en), .gen_key(gen_key),
    .gen_round_key(gen_round_key), .gen_w_e(gen_w_e), .gen_done(gen_done),
    .rd_round(rd_round), .rd_key(rd_key), .keys_ready(keys_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_gen();
    logic [127:0] k;
    int n;
    k = gen_key;
    n = (gen_mode == 1) ? 9 : 11;
    for (int i = 0; i < n; i++) begin
      if (gen_mode == 3 && i == 4) begin
        @(posedge clk); #1;
        gen_w_e = 1'b0; gen_done = 1'b0;
      end
      @(posedge clk); #1;
      if (!reset_n) break;
      gen_round_key = (k == KEY_B) ? RK_B[i] : RK_A[i];
      gen_w_e       = 1'b1;
      gen_done      = (i == n - 1) && (gen_mode != 2);
    end
    if (reset_n) begin
      @(posedge clk); #1;
    end
    gen_w_e = 1'b0; gen_done = 1'b0; gen_round_key = '0;
    if (gen_mode == 2 && reset_n) begin
      repeat (10) @(posedge clk);
      #1;
      gen_w_e = 1'b1; gen_done = 1'b1; gen_round_key = '1;
      @(posedge clk); #1;
      gen_w_e = 1'b0; gen_done = 1'b0; gen_round_key = '0;
    end
  endtask

  always @(negedge clk) begin
    if (gen_en === 1'b1) run_gen();
  end

  task automatic offer(input logic [127:0] k, output logic kr0);
    @(posedge clk); #1;
    key_in = k; key_valid = 1'b1;
    @(negedge clk);
    kr0 = key_ready;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_kr(input string tag, input int budget);
    int n;
    n = 0;
    while (keys_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, keys_ready, 1);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] r, input logic [127:0] exp);
    @(posedge clk); #1;
    rd_round = r;
    @(posedge clk);
    @(negedge clk);
    check(tag, rd_key, exp);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_key_ready"}, key_ready, 1);
    check({tag, "_gen_en"}, gen_en, 0);
    check({tag, "_gen_key"}, gen_key, 0);
    check({tag, "_rd_key"}, rd_key, 0);
    check({tag, "_keys_ready"}, keys_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic kr0;
    int n_busy, n_en, first_kr, n_krlow, n_rdylow, err_at, n_we;
    logic err12, busy12;

    #12;
    check_reset_outs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // first expansion of KEY_A, latency and busy window
    gen_mode = 0;
    offer(KEY_A, kr0);
    check("a_kr_at_offer", kr0, 1);
    n_busy = 0; n_en = 0; first_kr = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (gen_en) n_en++;
      if (keys_ready && first_kr == 0) first_kr = c;
    end
    check("a_busy_cycles", 128'(n_busy), 12);
    check("a_gen_en_pulses", 128'(n_en), 1);
    check("a_keys_ready_lat", 128'(first_kr), 13);
    read_chk("a_r0", 4'd0, RK_A[0]);
    read_chk("a_r1", 4'd1, RK_A[1]);
    read_chk("a_r10", 4'd10, RK_A[10]);

    // same key again: cache hit
    offer(KEY_A, kr0);
    check("hit_kr_at_offer", kr0, 1);
    n_en = 0; n_krlow = 0; n_rdylow = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (gen_en) n_en++;
      if (!keys_ready) n_krlow++;
      if (!key_ready) n_rdylow++;
    end
    check("hit_gen_en", 128'(n_en), 0);
    check("hit_keys_ready_drop", 128'(n_krlow), 0);
    check("hit_key_ready_drop", 128'(n_rdylow), 0);
    read_chk("hit_r10", 4'd10, RK_A[10]);

    // KEY_B miss with a gap in the strobes; read of round 10 held throughout
    gen_mode = 3;
    offer(KEY_B, kr0);
    @(negedge clk);
    check("b_rd_old_key", rd_key, RK_A[10]);
    check("b_keys_ready_drop", keys_ready, 0);
    @(negedge clk);
    check("b_rd_zero_expanding", rd_key, 0);
    wait_kr("b_done", 40);
    check("b_rd_zero_rise", rd_key, 0);
    @(negedge clk);
    check("b_r10", rd_key, RK_B[10]);
    read_chk("b_r0", 4'd0, RK_B[0]);

    // generator finishes after only 9 strobes
    gen_mode = 1;
    offer(KEY_A, kr0);
    n_busy = 0;
    while (busy === 1'b1 && n_busy < 30) begin
      @(negedge clk);
      n_busy++;
    end
    check("short_busy_end", busy, 0);
    check("short_err", err, 1);
    check("short_keys_ready", keys_ready, 0);
    check("short_key_ready", key_ready, 1);
    gen_mode = 0;
    offer(KEY_A, kr0);
    @(negedge clk);
    check("short_err_cleared", err, 0);
    wait_kr("short_recover", 30);
    read_chk("short_r10", 4'd10, RK_A[10]);

    // generator never finishes; a late strobe follows the timeout
    gen_mode = 2;
    rd_round = 4'd10;
    offer(KEY_B, kr0);
    err_at = 0; err12 = 1'b1; busy12 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 12) begin err12 = err; busy12 = busy; end
      if (err && err_at == 0) err_at = c;
    end
    check("tmo_no_early_err", err12, 0);
    check("tmo_busy_mid", busy12, 1);
    check("tmo_err_window", (err_at >= 17 && err_at <= 19), 1);
    check("tmo_err_sticky", err, 1);
    check("tmo_keys_ready", keys_ready, 0);
    check("tmo_idle", key_ready, 1);
    check("tmo_rd_zero", rd_key, 0);
    gen_mode = 0;
    offer(KEY_B, kr0);
    @(negedge clk);
    check("tmo_err_cleared", err, 0);
    wait_kr("tmo_recover", 30);
    read_chk("tmo_r10", 4'd10, RK_B[10]);

    // reset asserted on the 5th strobe of an expansion
    gen_mode = 0;
    offer(KEY_A, kr0);
    n_we = 0;
    for (int c = 0; c < 20 && n_we < 5; c++) begin
      @(negedge clk);
      if (gen_w_e) n_we++;
    end
    check("rst_mid_strobes", 128'(n_we), 5);
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    offer(KEY_B, kr0);
    @(negedge clk);
    check("rst_no_hit_gen_en", gen_en, 1);
    wait_kr("rst_reexpand", 30);
    read_chk("rst_r10", 4'd10, RK_B[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
